etapa_fetch: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage and the load-use hazard unit.

---
 rtl/etapa_fetch.sv | 112 +++++++++++
 tb/tb_etapa_fetch.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/etapa_fetch.sv
// rtl/etapa_fetch.sv - instruction fetch stage with IF/ID pipeline register
// Optional FETCH_STATS_EN adds saturating stall/flush counters.
module etapa_fetch #(
  parameter int unsigned              ADDR_W    = 32,
  parameter int unsigned              INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]        PC_STEP   = ADDR_W'(4),
  parameter logic [INSTR_W-1:0]       NOP_INSTR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PC_EN,
  input  logic                F_Reg_EN,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [INSTR_W-1:0]  instr_F,
  output logic [ADDR_W-1:0]   pc_F,
  output logic                valid_F
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
`endif
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, next_pc;
  logic              pc_adv, ifid_load, ifid_squash, ifid_boot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Branch squash outranks the load-use hold: the held ID instruction is wrong-path.
  always_comb begin
    pc_adv      = 1'b0;
    ifid_load   = 1'b0;
    ifid_squash = 1'b0;
    ifid_boot   = 1'b0;
    case (state_q)
      BOOT: ifid_boot = 1'b1;
      RUN: begin
        pc_adv = PC_EN;
        if (branch_taken) ifid_squash = 1'b1;
        else              ifid_load   = F_Reg_EN;
      end
      default: ifid_boot = 1'b1;
    endcase
  end

  always_comb begin
    if (branch_taken) next_pc = branch_target;
    else if (pc_adv)  next_pc = pc_q + PC_STEP;
    else              next_pc = pc_q;
  end

  // The memory registers this address, so its data lines up with pc_q next cycle.
  assign imem_addr = rst ? RESET_PC : next_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= next_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_F <= NOP_INSTR;
      pc_F    <= '0;
      valid_F <= 1'b0;
    end else if (ifid_squash) begin
      instr_F <= NOP_INSTR;
      pc_F    <= pc_q;
      valid_F <= 1'b0;
    end else if (ifid_boot) begin
      instr_F <= NOP_INSTR;
      valid_F <= 1'b0;
    end else if (ifid_load) begin
      instr_F <= imem_rdata;
      pc_F    <= pc_q;
      valid_F <= 1'b1;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state_q == RUN) begin
      if (branch_taken && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
      if (!branch_taken && !F_Reg_EN && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_etapa_fetch.sv
// tb/tb_etapa_fetch.sv - directed scoreboard bench for etapa_fetch
module tb_etapa_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_EN, F_Reg_EN, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_F, pc_F;
  logic        valid_F;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    string       tag;
  } exp_t;
  exp_t sb[$];

  etapa_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .PC_EN         (PC_EN),
    .F_Reg_EN      (F_Reg_EN),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_F       (instr_F),
    .pc_F          (pc_F),
    .valid_F       (valid_F)
`ifdef FETCH_STATS_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous memory whose contents equal the address.
  always @(posedge clk) imem_rdata <= imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic pe, input logic fe, input logic bt, input logic [31:0] tgt,
                      input logic [31:0] eaddr, input logic ev, input logic [31:0] epc,
                      input logic [31:0] ein, input string tag);
    exp_t e;
    PC_EN = pe; F_Reg_EN = fe; branch_taken = bt; branch_target = tgt;
    #1;
    chk({tag, ".imem_addr"}, imem_addr, eaddr);
    e.v = ev; e.pc = epc; e.ins = ein; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".valid_F"}, {31'd0, valid_F}, {31'd0, e.v});
    chk({e.tag, ".pc_F"}, pc_F, e.pc);
    chk({e.tag, ".instr_F"}, instr_F, e.ins);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; PC_EN = 1'b1; F_Reg_EN = 1'b1; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(negedge clk);
    chk("rst.valid_F", {31'd0, valid_F}, 32'd0);
    chk("rst.pc_F", pc_F, 32'd0);
    chk("rst.instr_F", instr_F, 32'd0);
    chk("rst.imem_addr", imem_addr, 32'd0);
    rst = 1'b0;

    step(1, 1, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        "boot1");
    step(1, 1, 0, 32'h0,        32'h4,        1, 32'h0,        32'h0,        "seq0");
    step(1, 1, 0, 32'h0,        32'h8,        1, 32'h4,        32'h4,        "seq4");
    step(1, 1, 0, 32'h0,        32'hC,        1, 32'h8,        32'h8,        "seq8");
    step(1, 1, 0, 32'h0,        32'h10,       1, 32'hC,        32'hC,        "seqC");
    step(0, 0, 0, 32'h0,        32'h10,       1, 32'hC,        32'hC,        "stall1");
    step(0, 0, 0, 32'h0,        32'h10,       1, 32'hC,        32'hC,        "stall2");
    step(1, 1, 0, 32'h0,        32'h14,       1, 32'h10,       32'h10,       "resume10");
    step(1, 1, 0, 32'h0,        32'h18,       1, 32'h14,       32'h14,       "seq14");
    step(1, 1, 0, 32'h0,        32'h1C,       1, 32'h18,       32'h18,       "seq18");
    step(1, 1, 0, 32'h0,        32'h20,       1, 32'h1C,       32'h1C,       "seq1C");
    step(1, 1, 1, 32'h100,      32'h100,      0, 32'h20,       32'h0,        "br100");
    step(1, 1, 0, 32'h0,        32'h104,      1, 32'h100,      32'h100,      "tgt100");
    step(1, 1, 0, 32'h0,        32'h108,      1, 32'h104,      32'h104,      "seq104");
    step(0, 0, 1, 32'h200,      32'h200,      0, 32'h108,      32'h0,        "br_over_stall");
    step(1, 1, 0, 32'h0,        32'h204,      1, 32'h200,      32'h200,      "tgt200");
    step(0, 1, 0, 32'h0,        32'h204,      1, 32'h204,      32'h204,      "dup_a");
    step(1, 1, 0, 32'h0,        32'h208,      1, 32'h204,      32'h204,      "dup_b");
    step(1, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h208,    32'h0,        "br_top");
    step(1, 1, 0, 32'h0,        32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "top");
    step(1, 1, 0, 32'h0,        32'h4,        1, 32'h0,        32'h0,        "wrap");

`ifdef FETCH_STATS_EN
    chk("stats.stall_cnt", stall_cnt, 32'd2);
    chk("stats.flush_cnt", flush_cnt, 32'd3);
`endif

    PC_EN = 1'b0; F_Reg_EN = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.valid_F", {31'd0, valid_F}, 32'd0);
    chk("arst.pc_F", pc_F, 32'd0);
    chk("arst.instr_F", instr_F, 32'd0);
    chk("arst.imem_addr", imem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step(1, 1, 1, 32'h40,       32'h40,       0, 32'h0,        32'h0,        "boot_br");
    step(1, 1, 0, 32'h0,        32'h44,       1, 32'h40,       32'h40,       "boot_tgt");

`ifdef FETCH_STATS_EN
    chk("stats_clr.stall_cnt", stall_cnt, 32'd0);
    chk("stats_clr.flush_cnt", flush_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
